// File: rtl/mac_seq_pkg.sv
// Shared types and widths for the MAC operand sequencer.
package mac_seq_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } pair_t;

endpackage

// File: rtl/mac_seq_fifo.sv
// Operand-pair buffer: synchronous FIFO of pair_t, show-ahead head entry.
module mac_seq_fifo
    import mac_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  pair_t din,
    input  logic  pop,
    output pair_t dout,
    output logic  full,
    output logic  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    pair_t              mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic               push_en;
    logic               pop_en;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Drives a pipelined 8x8 signed MAC: buffers operand pairs, clears the
// accumulator, issues pairs, counts returns and captures the final sum.
// Optional watchdog in DRAIN enabled by defining MAC_SEQ_TIMEOUT_EN.
module mac_operand_sequencer
    import mac_seq_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_a,
    input  logic [DATA_W-1:0] load_b,
    output logic              load_ready,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    output logic              busy,
    output logic              mac_clr,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_valid_in,
    input  logic [ACC_W-1:0]  mac_f,
    input  logic              mac_overflow,
    input  logic              mac_valid_out,
    output logic [ACC_W-1:0]  result,
    output logic              result_ovf,
    output logic              result_to,
    output logic              done
);

    seq_state_t         state_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   issued_reg;
    logic [LEN_W-1:0]   returned_reg;
    logic               mac_clr_reg;
    logic [DATA_W-1:0]  mac_a_reg;
    logic [DATA_W-1:0]  mac_b_reg;
    logic               mac_valid_in_reg;
    logic [ACC_W-1:0]   result_reg;
    logic               result_ovf_reg;
    logic               done_reg;

    pair_t              load_pair;
    pair_t              head_pair;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;

    assign load_pair = '{a: load_a, b: load_b};
    // Pop exactly when ISSUE registers a pair into the MAC operand registers.
    assign fifo_pop  = (state_reg == ISSUE) && !fifo_empty;

    mac_seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (load_valid),
        .din   (load_pair),
        .pop   (fifo_pop),
        .dout  (head_pair),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef MAC_SEQ_TIMEOUT_EN
    localparam int WD_LIMIT = 4 * MAC_LAT;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);
    logic [WD_W-1:0] wd_reg;
    logic            result_to_reg;
    assign result_to = result_to_reg;
`else
    assign result_to = 1'b0;
`endif

    assign load_ready   = !fifo_full;
    assign busy         = (state_reg != IDLE);
    assign mac_clr      = mac_clr_reg;
    assign mac_a        = mac_a_reg;
    assign mac_b        = mac_b_reg;
    assign mac_valid_in = mac_valid_in_reg;
    assign result       = result_reg;
    assign result_ovf   = result_ovf_reg;
    assign done         = done_reg;

    // Run-control FSM with all MAC-facing and result outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= IDLE;
            len_reg          <= '0;
            issued_reg       <= '0;
            returned_reg     <= '0;
            mac_clr_reg      <= 1'b1;
            mac_a_reg        <= '0;
            mac_b_reg        <= '0;
            mac_valid_in_reg <= 1'b0;
            result_reg       <= '0;
            result_ovf_reg   <= 1'b0;
            done_reg         <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
            wd_reg           <= '0;
            result_to_reg    <= 1'b0;
`endif
        end else begin
            // Pulse-style outputs default low; ISSUE overrides on a pop.
            mac_clr_reg      <= 1'b0;
            done_reg         <= 1'b0;
            mac_valid_in_reg <= 1'b0;
            mac_a_reg        <= '0;
            mac_b_reg        <= '0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (vec_len != '0) begin
                            len_reg   <= vec_len;
                            state_reg <= CLEAR;
                        end else begin
                            // Empty run completes immediately without touching the MAC.
                            result_reg     <= '0;
                            result_ovf_reg <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
                            result_to_reg  <= 1'b0;
`endif
                            done_reg       <= 1'b1;
                            state_reg      <= DONE;
                        end
                    end
                end
                CLEAR: begin
                    mac_clr_reg    <= 1'b1;
                    issued_reg     <= '0;
                    returned_reg   <= '0;
                    result_ovf_reg <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
                    wd_reg         <= '0;
                    result_to_reg  <= 1'b0;
`endif
                    state_reg      <= ISSUE;
                end
                ISSUE: begin
                    if (!fifo_empty) begin
                        mac_a_reg        <= head_pair.a;
                        mac_b_reg        <= head_pair.b;
                        mac_valid_in_reg <= 1'b1;
                        issued_reg       <= issued_reg + LEN_W'(1);
                        if (issued_reg + LEN_W'(1) == len_reg) begin
                            state_reg <= DRAIN;
                        end
                    end
                    if (mac_valid_out) begin
                        returned_reg   <= returned_reg + LEN_W'(1);
                        result_ovf_reg <= result_ovf_reg | mac_overflow;
                    end
                end
                DRAIN: begin
                    if (mac_valid_out) begin
                        returned_reg   <= returned_reg + LEN_W'(1);
                        result_ovf_reg <= result_ovf_reg | mac_overflow;
                        if (returned_reg + LEN_W'(1) == len_reg) begin
                            result_reg <= mac_f;
                            done_reg   <= 1'b1;
                            state_reg  <= DONE;
                        end
                    end
`ifdef MAC_SEQ_TIMEOUT_EN
                    // Watchdog restarts on every return; expiry captures whatever the MAC holds.
                    if (mac_valid_out) begin
                        wd_reg <= '0;
                    end else if (wd_reg == WD_W'(WD_LIMIT - 1)) begin
                        result_reg    <= mac_f;
                        result_to_reg <= 1'b1;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        wd_reg <= wd_reg + WD_W'(1);
                    end
`endif
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Self-checking bench for mac_operand_sequencer with a behavioural MAC responder.
module tb_mac_operand_sequencer;

    localparam int DEPTH   = 8;
    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [7:0]        load_a;
    logic [7:0]        load_b;
    logic              load_ready;
    logic              start;
    logic [LEN_W-1:0]  vec_len;
    logic              busy;
    logic              mac_clr;
    logic [7:0]        mac_a;
    logic [7:0]        mac_b;
    logic              mac_valid_in;
    logic [15:0]       mac_f;
    logic              mac_overflow;
    logic              mac_valid_out;
    logic [15:0]       result;
    logic              result_ovf;
    logic              result_to;
    logic              done;

    always #5 clk = ~clk;

    mac_operand_sequencer #(
        .DEPTH   (DEPTH),
        .LEN_W   (LEN_W),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_valid    (load_valid),
        .load_a        (load_a),
        .load_b        (load_b),
        .load_ready    (load_ready),
        .start         (start),
        .vec_len       (vec_len),
        .busy          (busy),
        .mac_clr       (mac_clr),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_valid_in  (mac_valid_in),
        .mac_f         (mac_f),
        .mac_overflow  (mac_overflow),
        .mac_valid_out (mac_valid_out),
        .result        (result),
        .result_ovf    (result_ovf),
        .result_to     (result_to),
        .done          (done)
    );

    // ---------------- behavioural MAC: accumulate, flag step overflow, fixed latency
    logic               mac_mute = 1'b0;
    logic signed [15:0] acc_m = '0;
    logic               stg_v [MAC_LAT];
    logic [15:0]        stg_f [MAC_LAT];
    logic               stg_o [MAC_LAT];
    int                 nxt;
    logic               nxt_o;

    always @(posedge clk) begin
        nxt   = int'(acc_m);
        nxt_o = 1'b0;
        if (mac_clr) begin
            nxt = 0;
        end else if (mac_valid_in) begin
            nxt   = int'(acc_m) + int'($signed(mac_a)) * int'($signed(mac_b));
            nxt_o = (nxt > 32767) || (nxt < -32768);
        end
        acc_m    <= 16'(nxt);
        stg_v[0] <= mac_valid_in && !mac_clr;
        stg_f[0] <= 16'(nxt);
        stg_o[0] <= nxt_o;
        for (int i = 1; i < MAC_LAT; i++) begin
            stg_v[i] <= stg_v[i-1];
            stg_f[i] <= stg_f[i-1];
            stg_o[i] <= stg_o[i-1];
        end
    end
    assign mac_valid_out = stg_v[MAC_LAT-1] && !mac_mute;
    assign mac_f         = stg_f[MAC_LAT-1];
    assign mac_overflow  = stg_o[MAC_LAT-1];

    // ---------------- cycle counter and event monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int done_total = 0, vin_total = 0, vin_since_clr = 0;
    int done_cyc = 0, clr_cyc = 0, first_vin_cyc = 0, last_vin_cyc = 0;
    always @(negedge clk) begin
        if (done) begin
            done_total = done_total + 1;
            done_cyc   = cyc;
        end
        if (mac_clr) begin
            clr_cyc       = cyc;
            vin_since_clr = 0;
        end
        if (mac_valid_in) begin
            if (vin_since_clr == 0) first_vin_cyc = cyc;
            vin_since_clr = vin_since_clr + 1;
            vin_total     = vin_total + 1;
            last_vin_cyc  = cyc;
        end
    end

    // ---------------- reference model: queue of accepted pairs, plain arithmetic
    typedef struct { int a; int b; } mpair_t;
    mpair_t model_q [$];

    function automatic void ref_run(input int n, output int res, output bit ovf);
        int acc;
        logic signed [15:0] w;
        mpair_t p;
        acc = 0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            p   = model_q.pop_front();
            acc = acc + p.a * p.b;
            if (acc > 32767 || acc < -32768) ovf = 1'b1;
            w   = acc[15:0];
            acc = int'(w);
        end
        res = acc;
    endfunction

    // ---------------- checking helpers
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic load_pair(input logic [7:0] a, input logic [7:0] b);
        mpair_t p;
        load_valid = 1'b1;
        load_a     = a;
        load_b     = b;
        check("load_ready", int'(load_ready), int'(model_q.size() < DEPTH));
        if (model_q.size() < DEPTH) begin
            p.a = int'($signed(a));
            p.b = int'($signed(b));
            model_q.push_back(p);
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    int d0_done, d0_vin, start_cyc;

    task automatic start_run(input int n);
        d0_done   = done_total;
        d0_vin    = vin_total;
        start_cyc = cyc;
        start     = 1'b1;
        vec_len   = LEN_W'(n);
        @(negedge clk);
        start     = 1'b0;
        vec_len   = '0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (done_total == d0_done && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (done_total == d0_done) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: got no done expected done within 300 cycles", name);
        end
    endtask

    task automatic finish_run(input int n, input int exp_r, input bit exp_o, input string name);
        wait_done(name);
        repeat (3) @(negedge clk);
        check({name, ".done_count"}, done_total - d0_done, 1);
        check({name, ".result"}, int'($signed(result)), exp_r);
        check({name, ".result_ovf"}, int'(result_ovf), int'(exp_o));
        check({name, ".result_to"}, int'(result_to), 0);
        check({name, ".issues"}, vin_total - d0_vin, n);
        check({name, ".busy"}, int'(busy), 0);
        if (n > 0) begin
            check({name, ".done_timing"}, done_cyc, last_vin_cyc + MAC_LAT + 1);
            check({name, ".clr_to_issue"}, first_vin_cyc, clr_cyc + 1);
        end else begin
            check({name, ".fast_done"}, int'(done_cyc - start_cyc <= 2), 1);
        end
    endtask

    // ---------------- directed vector table
    typedef struct {
        string name;
        int    n;
        int    a [4];
        int    b [4];
        int    exp_r;
        bit    exp_o;
    } vec_t;
    vec_t tbl [6];

    task automatic setv(input int i, input string nm, input int n,
                        input int a0, input int b0, input int a1, input int b1,
                        input int a2, input int b2, input int a3, input int b3,
                        input int r, input bit o);
        tbl[i].name = nm;  tbl[i].n = n;
        tbl[i].a[0] = a0;  tbl[i].b[0] = b0;
        tbl[i].a[1] = a1;  tbl[i].b[1] = b1;
        tbl[i].a[2] = a2;  tbl[i].b[2] = b2;
        tbl[i].a[3] = a3;  tbl[i].b[3] = b3;
        tbl[i].exp_r = r;  tbl[i].exp_o = o;
    endtask

    int er;
    bit eo;

    initial begin
        setv(0, "dot2",     2,    2,   2,   3,   3,  0,   0,  0,  0,     13, 1'b0);
        setv(1, "len0",     0,    0,   0,   0,   0,  0,   0,  0,  0,      0, 1'b0);
        setv(2, "sat127x3", 3,  127, 127, 127, 127, 127, 127, 0,  0, -17149, 1'b1);
        setv(3, "neg_mix",  2, -128,-128,  -1,   5,  0,   0,  0,  0,  16379, 1'b0);
        setv(4, "near_min", 2, -128, 127,-128, 127,  0,   0,  0,  0, -32512, 1'b0);
        setv(5, "four",     4,  100,-100,  50,  50, -7,   9, 10, 10,  -7463, 1'b0);

        reset      = 1'b0;
        load_valid = 1'b0;
        load_a     = '0;
        load_b     = '0;
        start      = 1'b0;
        vec_len    = '0;
        repeat (5) @(negedge clk);
        check("rst.mac_clr", int'(mac_clr), 1);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.mac_valid_in", int'(mac_valid_in), 0);
        check("rst.mac_a", int'(mac_a), 0);
        check("rst.result", int'(result), 0);
        check("rst.result_ovf", int'(result_ovf), 0);
        check("rst.result_to", int'(result_to), 0);
        check("rst.load_ready", int'(load_ready), 1);
        reset = 1'b1;
        @(negedge clk);
        check("idle.mac_clr", int'(mac_clr), 0);

        // Table-driven directed runs.
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < tbl[v].n; k++) begin
                load_pair(8'(tbl[v].a[k]), 8'(tbl[v].b[k]));
            end
            ref_run(tbl[v].n, er, eo);
            start_run(tbl[v].n);
            finish_run(tbl[v].n, tbl[v].exp_r, tbl[v].exp_o, tbl[v].name);
        end

        // Stalled run: one pair buffered, rest arrive later; a stray start mid-run is ignored.
        load_pair(8'd7, 8'd6);
        start_run(3);
        repeat (2) @(negedge clk);
        start   = 1'b1;
        vec_len = LEN_W'(1);
        @(negedge clk);
        start   = 1'b0;
        vec_len = '0;
        repeat (2) @(negedge clk);
        load_pair(8'hF6, 8'd4);
        load_pair(8'd9, 8'd9);
        ref_run(3, er, eo);
        finish_run(3, er, eo, "gap");
        check("gap.spread", int'(last_vin_cyc - first_vin_cyc > 2), 1);

        // Overfill: nine pushes, ninth dropped, run of eight uses the first eight.
        for (int k = 0; k < 9; k++) begin
            load_pair(8'(k + 1), 8'(k + 3));
        end
        check("full.load_ready", int'(load_ready), 0);
        ref_run(8, er, eo);
        start_run(8);
        finish_run(8, er, eo, "full8");
        check("full8.drained", int'(load_ready), 1);

        // Reset in the middle of ISSUE aborts the run.
        for (int k = 0; k < 4; k++) load_pair(8'(k + 2), 8'(5));
        start_run(4);
        begin
            int t;
            t = 0;
            while (vin_total - d0_vin < 2 && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("midrst.reached_issue", int'(vin_total - d0_vin >= 2), 1);
        end
        reset = 1'b0;
        @(negedge clk);
        model_q.delete();
        check("midrst.mac_clr", int'(mac_clr), 1);
        check("midrst.mac_valid_in", int'(mac_valid_in), 0);
        check("midrst.mac_a", int'(mac_a), 0);
        check("midrst.busy", int'(busy), 0);
        check("midrst.result", int'(result), 0);
        check("midrst.done", int'(done), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst.no_done", done_total - d0_done, 0);
        check("midrst.empty", int'(load_ready), 1);
        load_pair(8'd11, 8'hFD);
        load_pair(8'd4, 8'd4);
        ref_run(2, er, eo);
        start_run(2);
        finish_run(2, er, eo, "post_rst");

        // Randomised runs against the reference model.
        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            while (model_q.size() < n) begin
                load_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
            if (model_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                load_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
            ref_run(n, er, eo);
            start_run(n);
            finish_run(n, er, eo, $sformatf("rand%0d", r));
        end

`ifdef MAC_SEQ_TIMEOUT_EN
        // Watchdog: MAC never answers, run completes on timeout.
        model_q.delete();
        while (!load_ready) @(negedge clk);
        mac_mute = 1'b1;
        load_pair(8'd3, 8'd5);
        load_pair(8'd2, 8'd2);
        ref_run(2, er, eo);
        start_run(2);
        wait_done("timeout");
        @(negedge clk);
        check("timeout.done_timing", done_cyc, last_vin_cyc + 4 * MAC_LAT);
        check("timeout.result_to", int'(result_to), 1);
        check("timeout.result", int'($signed(result)), er);
        mac_mute = 1'b0;
        repeat (5) @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
